uart_mem_arbiter: RTL and testbench

//  Round-robin arbiter that shares one uart_mem slave port (enable/wr_en/addr/i_data/be -> ready/o_data/bus_err)

---
 rtl/uart_mem_arbiter_pkg.sv | 22 ++
 rtl/uart_mem_arbiter_rr_pick.sv | 48 ++++
 rtl/uart_mem_arbiter.sv | 194 +++++++++++++++++++
 tb/tb_uart_mem_arbiter.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_mem_arbiter_pkg.sv
// Shared definitions for the uart_mem round-robin arbiter.
//   arb_state_e : arbiter FSM encoding (IDLE = no access downstream, BUSY = one access in flight)
//   ARB_MAX_REQ : largest supported requester count
//   ARB_GID_W   : width of a requester index / grant id
//   rr_next     : round-robin successor of a requester index
package uart_mem_arbiter_pkg;

  localparam int ARB_MAX_REQ = 8;
  localparam int ARB_GID_W   = 3;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_e;

  // Index after id, wrapping from num_req-1 back to 0.
  function automatic logic [ARB_GID_W-1:0] rr_next(input logic [ARB_GID_W-1:0] id,
                                                   input int num_req);
    return (int'(id) == num_req - 1) ? '0 : id + ARB_GID_W'(1);
  endfunction

endpackage

// File: rtl/uart_mem_arbiter_rr_pick.sv
// Rotating-priority encoder: returns the first set request bit at or after
// the pointer, wrapping at NUM_REQ-1 -> 0. Purely combinational.
//   req   in  NUM_REQ    request vector
//   ptr   in  ARB_GID_W  highest-priority index (must be < NUM_REQ)
//   valid out 1          any request set
//   idx   out ARB_GID_W  winning index (0 when valid is low)
module uart_mem_arbiter_rr_pick
  import uart_mem_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0]   req,
  input  logic [ARB_GID_W-1:0] ptr,
  output logic                 valid,
  output logic [ARB_GID_W-1:0] idx
);

  // Padded copy so a full-width index never selects past the vector.
  logic [ARB_MAX_REQ-1:0] req_pad;
  assign req_pad = ARB_MAX_REQ'(req);

  // cand[k] = (ptr + k) mod NUM_REQ; one subtract suffices because ptr < NUM_REQ.
  logic [NUM_REQ-1:0][ARB_GID_W:0]   sum;
  logic [NUM_REQ-1:0][ARB_GID_W-1:0] cand;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_cand
      assign sum[gi]  = {1'b0, ptr} + (ARB_GID_W+1)'(gi);
      assign cand[gi] = (sum[gi] >= (ARB_GID_W+1)'(NUM_REQ))
                        ? ARB_GID_W'(sum[gi] - (ARB_GID_W+1)'(NUM_REQ))
                        : sum[gi][ARB_GID_W-1:0];
    end
  endgenerate

  // Scan from the far end so the smallest offset from ptr wins.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_pad[cand[k]]) begin
        valid = 1'b1;
        idx   = cand[k];
      end
    end
  end

endmodule

// File: rtl/uart_mem_arbiter.sv
// Round-robin arbiter sharing one uart_mem slave port between NUM_REQ masters.
// Exactly one access is in flight downstream; the slave request is registered
// on grant and held until s_ready, and completion passes straight back to the
// granted master in the same cycle.
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   req_enable/wr_en/addr/i_data/be per-requester request (packed, slice i)
//   req_ready/req_o_data/req_bus_err completion strobe, read data, error
//   s_enable/wr_en/addr/i_data/be   registered request to uart_mem
//   s_ready/s_o_data/s_bus_err      response from uart_mem
//   grant_id                        current/last granted requester
// Build option: define UART_ARB_TIMEOUT_EN to abort an access that has waited
// TIMEOUT_CYCLES BUSY cycles for s_ready (completes with bus_err, data 0).
module uart_mem_arbiter
  import uart_mem_arbiter_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req_enable,
  input  logic [NUM_REQ-1:0]     req_wr_en,
  input  logic [NUM_REQ*32-1:0]  req_addr,
  input  logic [NUM_REQ*32-1:0]  req_i_data,
  input  logic [NUM_REQ*4-1:0]   req_be,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [31:0]            req_o_data,
  output logic [NUM_REQ-1:0]     req_bus_err,
  output logic                   s_enable,
  output logic                   s_wr_en,
  output logic [31:0]            s_addr,
  output logic [31:0]            s_i_data,
  output logic [3:0]             s_be,
  input  logic                   s_ready,
  input  logic [31:0]            s_o_data,
  input  logic                   s_bus_err,
  output logic [ARB_GID_W-1:0]   grant_id
);

  // Unpack requester buses into arrays padded to ARB_MAX_REQ entries.
  logic [ARB_MAX_REQ-1:0] wr_en_arr;
  logic [31:0]            addr_arr [ARB_MAX_REQ];
  logic [31:0]            data_arr [ARB_MAX_REQ];
  logic [3:0]             be_arr   [ARB_MAX_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < ARB_MAX_REQ; gi++) begin : g_unpack
      if (gi < NUM_REQ) begin : g_used
        assign wr_en_arr[gi] = req_wr_en[gi];
        assign addr_arr[gi]  = req_addr[32*gi +: 32];
        assign data_arr[gi]  = req_i_data[32*gi +: 32];
        assign be_arr[gi]    = req_be[4*gi +: 4];
      end else begin : g_pad
        assign wr_en_arr[gi] = 1'b0;
        assign addr_arr[gi]  = '0;
        assign data_arr[gi]  = '0;
        assign be_arr[gi]    = '0;
      end
    end
  endgenerate

  arb_state_e             state_q, state_d;
  logic                   s_enable_q, s_enable_d;
  logic                   s_wr_en_q, s_wr_en_d;
  logic [31:0]            s_addr_q, s_addr_d;
  logic [31:0]            s_i_data_q, s_i_data_d;
  logic [3:0]             s_be_q, s_be_d;
  logic [ARB_GID_W-1:0]   grant_q, grant_d;
  logic [ARB_GID_W-1:0]   ptr_q, ptr_d;

  logic                   pick_valid;
  logic [ARB_GID_W-1:0]   pick_idx;
  logic                   done;
  logic                   done_err;
  logic [31:0]            done_data;

`ifdef UART_ARB_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0]            tmo_cnt_q, tmo_cnt_d;
  logic                   tmo_hit;
`endif

  uart_mem_arbiter_rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .req   (req_enable),
    .ptr   (ptr_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  always_comb begin
    state_d    = state_q;
    s_enable_d = s_enable_q;
    s_wr_en_d  = s_wr_en_q;
    s_addr_d   = s_addr_q;
    s_i_data_d = s_i_data_q;
    s_be_d     = s_be_q;
    grant_d    = grant_q;
    ptr_d      = ptr_q;
    done       = 1'b0;
    done_err   = s_bus_err;
    done_data  = s_o_data;
`ifdef UART_ARB_TIMEOUT_EN
    tmo_cnt_d  = tmo_cnt_q;
    tmo_hit    = 1'b0;
`endif
    case (state_q)
      ARB_IDLE: begin
        if (pick_valid) begin
          s_enable_d = 1'b1;
          s_wr_en_d  = wr_en_arr[pick_idx];
          s_addr_d   = addr_arr[pick_idx];
          s_i_data_d = data_arr[pick_idx];
          s_be_d     = be_arr[pick_idx];
          grant_d    = pick_idx;
          state_d    = ARB_BUSY;
`ifdef UART_ARB_TIMEOUT_EN
          tmo_cnt_d  = '0;
`endif
        end
      end
      ARB_BUSY: begin
`ifdef UART_ARB_TIMEOUT_EN
        // Counter holds the number of BUSY cycles already spent without s_ready.
        if (!s_ready) begin
          if (tmo_cnt_q == TIMEOUT_LAST) tmo_hit = 1'b1;
          else                           tmo_cnt_d = tmo_cnt_q + 16'd1;
        end
        if (tmo_hit) begin
          done_err  = 1'b1;
          done_data = '0;
        end
        done = s_ready | tmo_hit;
`else
        done = s_ready;
`endif
        if (done) begin
          s_enable_d = 1'b0;
          ptr_d      = rr_next(grant_q, NUM_REQ);
          state_d    = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // Completion is steered only to the granted requester.
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_resp
      assign req_ready[gi]   = done && (grant_q == ARB_GID_W'(gi));
      assign req_bus_err[gi] = done && done_err && (grant_q == ARB_GID_W'(gi));
    end
  endgenerate

  assign req_o_data = done_data;
  assign s_enable   = s_enable_q;
  assign s_wr_en    = s_wr_en_q;
  assign s_addr     = s_addr_q;
  assign s_i_data   = s_i_data_q;
  assign s_be       = s_be_q;
  assign grant_id   = grant_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ARB_IDLE;
      s_enable_q <= 1'b0;
      s_wr_en_q  <= 1'b0;
      s_addr_q   <= '0;
      s_i_data_q <= '0;
      s_be_q     <= '0;
      grant_q    <= '0;
      ptr_q      <= '0;
`ifdef UART_ARB_TIMEOUT_EN
      tmo_cnt_q  <= '0;
`endif
    end else begin
      state_q    <= state_d;
      s_enable_q <= s_enable_d;
      s_wr_en_q  <= s_wr_en_d;
      s_addr_q   <= s_addr_d;
      s_i_data_q <= s_i_data_d;
      s_be_q     <= s_be_d;
      grant_q    <= grant_d;
      ptr_q      <= ptr_d;
`ifdef UART_ARB_TIMEOUT_EN
      tmo_cnt_q  <= tmo_cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_mem_arbiter.sv
module tb_uart_mem_arbiter;

  localparam int          N      = 2;
  localparam logic [31:0] BAUD_L = 32'h0000_0010;
  localparam logic [31:0] STATUS = 32'h0000_0004;
  localparam logic [31:0] CTRL   = 32'h0000_000C;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req_enable = '0;
  logic [N-1:0]    req_wr_en = '0;
  logic [N*32-1:0] req_addr = '0;
  logic [N*32-1:0] req_i_data = '0;
  logic [N*4-1:0]  req_be = '0;
  logic [N-1:0]    req_ready;
  logic [31:0]     req_o_data;
  logic [N-1:0]    req_bus_err;
  logic            s_enable;
  logic            s_wr_en;
  logic [31:0]     s_addr;
  logic [31:0]     s_i_data;
  logic [3:0]      s_be;
  logic            s_ready = 1'b0;
  logic [31:0]     s_o_data = '0;
  logic            s_bus_err = 1'b0;
  logic [2:0]      grant_id;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  uart_mem_arbiter #(
    .NUM_REQ        (N),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_enable  (req_enable),
    .req_wr_en   (req_wr_en),
    .req_addr    (req_addr),
    .req_i_data  (req_i_data),
    .req_be      (req_be),
    .req_ready   (req_ready),
    .req_o_data  (req_o_data),
    .req_bus_err (req_bus_err),
    .s_enable    (s_enable),
    .s_wr_en     (s_wr_en),
    .s_addr      (s_addr),
    .s_i_data    (s_i_data),
    .s_be        (s_be),
    .s_ready     (s_ready),
    .s_o_data    (s_o_data),
    .s_bus_err   (s_bus_err),
    .grant_id    (grant_id)
  );

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic en, input logic wr,
                         input logic [31:0] addr, input logic [31:0] data,
                         input logic [3:0] be);
    req_enable[i]        = en;
    req_wr_en[i]         = wr;
    req_addr[32*i +: 32] = addr;
    req_i_data[32*i +: 32] = data;
    req_be[4*i +: 4]     = be;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    #1;
    tests_run++; if (s_enable !== 1'b0) begin tests_failed++; $display("FAIL reset_s_enable: got %b expected 0", s_enable); end
    tests_run++; if (s_wr_en !== 1'b0) begin tests_failed++; $display("FAIL reset_s_wr_en: got %b expected 0", s_wr_en); end
    tests_run++; if ({s_addr, s_i_data, s_be} !== 68'h0) begin tests_failed++; $display("FAIL reset_s_bus: got %h/%h/%h expected 0/0/0", s_addr, s_i_data, s_be); end
    tests_run++; if (grant_id !== 3'd0) begin tests_failed++; $display("FAIL reset_grant_id: got %0d expected 0", grant_id); end
    s_ready = 1'b1;
    #1;
    tests_run++; if (req_ready !== 2'b00) begin tests_failed++; $display("FAIL reset_req_ready: got %b expected 00", req_ready); end
    s_ready = 1'b0;
    rst_n   = 1'b1;
    $display("[TB] reset released");
  endtask

  task automatic test_write();
    step();
    set_req(0, 1'b1, 1'b1, BAUD_L, 32'h0000_00D5, 4'b0001);
    #1;
    tests_run++; if (s_enable !== 1'b0) begin tests_failed++; $display("FAIL write_pre_grant: got %b expected 0", s_enable); end
    step();
    #1;
    tests_run++; if (s_enable !== 1'b1) begin tests_failed++; $display("FAIL write_s_enable: got %b expected 1", s_enable); end
    tests_run++; if (s_wr_en !== 1'b1) begin tests_failed++; $display("FAIL write_s_wr_en: got %b expected 1", s_wr_en); end
    tests_run++; if (s_addr !== BAUD_L) begin tests_failed++; $display("FAIL write_s_addr: got %h expected %h", s_addr, BAUD_L); end
    tests_run++; if (s_i_data !== 32'h0000_00D5) begin tests_failed++; $display("FAIL write_s_i_data: got %h expected 000000d5", s_i_data); end
    tests_run++; if (s_be !== 4'b0001) begin tests_failed++; $display("FAIL write_s_be: got %b expected 0001", s_be); end
    tests_run++; if (req_ready !== 2'b00) begin tests_failed++; $display("FAIL write_no_early_ready: got %b expected 00", req_ready); end
    s_ready = 1'b1;
    #1;
    tests_run++; if (req_ready !== 2'b01) begin tests_failed++; $display("FAIL write_req_ready: got %b expected 01", req_ready); end
    tests_run++; if (req_bus_err !== 2'b00) begin tests_failed++; $display("FAIL write_req_bus_err: got %b expected 00", req_bus_err); end
    $display("[TB] write req0 addr=%h data=%h ready=%b", s_addr, s_i_data, req_ready);
    step();
    s_ready = 1'b0;
    set_req(0, 1'b0, 1'b0, '0, '0, '0);
    #1;
    tests_run++; if (s_enable !== 1'b0) begin tests_failed++; $display("FAIL write_s_enable_drop: got %b expected 0", s_enable); end
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_rdy;
    int         exp_gid;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    set_req(0, 1'b1, 1'b1, CTRL, 32'h0000_0011, 4'hF);
    set_req(1, 1'b1, 1'b1, CTRL, 32'h0000_0022, 4'hF);
    for (int k = 0; k < 4; k++) begin
      exp_gid = k % 2;
      exp_rdy = 2'b01 << exp_gid;
      step();
      #1;
      tests_run++; if (s_enable !== 1'b1) begin tests_failed++; $display("FAIL rr_s_enable[%0d]: got %b expected 1", k, s_enable); end
      tests_run++; if (grant_id !== 3'(exp_gid)) begin tests_failed++; $display("FAIL rr_grant[%0d]: got %0d expected %0d", k, grant_id, exp_gid); end
      tests_run++; if (s_i_data !== (exp_gid == 0 ? 32'h11 : 32'h22)) begin tests_failed++; $display("FAIL rr_s_i_data[%0d]: got %h expected requester %0d data", k, s_i_data, exp_gid); end
      s_ready = 1'b1;
      #1;
      tests_run++; if (req_ready !== exp_rdy) begin tests_failed++; $display("FAIL rr_req_ready[%0d]: got %b expected %b", k, req_ready, exp_rdy); end
      $display("[TB] rr access %0d granted req%0d ready=%b", k, grant_id, req_ready);
      step();
      s_ready = 1'b0;
      #1;
      tests_run++; if (s_enable !== 1'b0) begin tests_failed++; $display("FAIL rr_idle_gap[%0d]: got %b expected 0", k, s_enable); end
    end
    set_req(0, 1'b0, 1'b0, '0, '0, '0);
    set_req(1, 1'b0, 1'b0, '0, '0, '0);
  endtask

  task automatic test_read();
    set_req(1, 1'b1, 1'b0, STATUS, '0, 4'hF);
    step();
    #1;
    tests_run++; if (grant_id !== 3'd1) begin tests_failed++; $display("FAIL read_grant: got %0d expected 1", grant_id); end
    tests_run++; if (s_wr_en !== 1'b0) begin tests_failed++; $display("FAIL read_s_wr_en: got %b expected 0", s_wr_en); end
    tests_run++; if (s_addr !== STATUS) begin tests_failed++; $display("FAIL read_s_addr: got %h expected %h", s_addr, STATUS); end
    s_o_data = 32'h0000_0003;
    s_ready  = 1'b1;
    #1;
    tests_run++; if (req_o_data !== 32'h0000_0003) begin tests_failed++; $display("FAIL read_o_data: got %h expected 00000003", req_o_data); end
    tests_run++; if (req_ready !== 2'b10) begin tests_failed++; $display("FAIL read_req_ready: got %b expected 10", req_ready); end
    tests_run++; if (req_bus_err !== 2'b00) begin tests_failed++; $display("FAIL read_bus_err: got %b expected 00", req_bus_err); end
    $display("[TB] read req1 addr=%h data=%h ready=%b", s_addr, req_o_data, req_ready);
    step();
    s_ready  = 1'b0;
    s_o_data = '0;
    set_req(1, 1'b0, 1'b0, '0, '0, '0);
    #1;
  endtask

  task automatic test_bus_err();
    set_req(0, 1'b1, 1'b1, CTRL, 32'h0000_0055, 4'hF);
    step();
    #1;
    tests_run++; if (grant_id !== 3'd0) begin tests_failed++; $display("FAIL err_grant: got %0d expected 0", grant_id); end
    s_bus_err = 1'b1;
    s_ready   = 1'b1;
    #1;
    tests_run++; if (req_bus_err !== 2'b01) begin tests_failed++; $display("FAIL err_flag: got %b expected 01", req_bus_err); end
    tests_run++; if (req_ready !== 2'b01) begin tests_failed++; $display("FAIL err_ready: got %b expected 01", req_ready); end
    $display("[TB] error access req0 ready=%b bus_err=%b", req_ready, req_bus_err);
    step();
    set_req(0, 1'b0, 1'b0, '0, '0, '0);
    #1;
    tests_run++; if (req_bus_err !== 2'b00) begin tests_failed++; $display("FAIL err_one_cycle: got %b expected 00", req_bus_err); end
    tests_run++; if (req_ready !== 2'b00) begin tests_failed++; $display("FAIL err_idle_ready: got %b expected 00", req_ready); end
    s_ready   = 1'b0;
    s_bus_err = 1'b0;
    set_req(0, 1'b1, 1'b1, CTRL, 32'h0000_0066, 4'hF);
    step();
    #1;
    s_ready = 1'b1;
    #1;
    tests_run++; if (req_ready !== 2'b01) begin tests_failed++; $display("FAIL err_next_ready: got %b expected 01", req_ready); end
    tests_run++; if (req_bus_err !== 2'b00) begin tests_failed++; $display("FAIL err_next_clean: got %b expected 00", req_bus_err); end
    $display("[TB] clean access req0 ready=%b bus_err=%b", req_ready, req_bus_err);
    step();
    s_ready = 1'b0;
    set_req(0, 1'b0, 1'b0, '0, '0, '0);
    #1;
  endtask

  task automatic test_drop_while_granted();
    set_req(0, 1'b1, 1'b0, STATUS, '0, 4'hF);
    step();
    set_req(0, 1'b0, 1'b0, '0, '0, '0);
    #1;
    tests_run++; if (grant_id !== 3'd0) begin tests_failed++; $display("FAIL drop_grant: got %0d expected 0", grant_id); end
    step();
    #1;
    tests_run++; if (s_enable !== 1'b1) begin tests_failed++; $display("FAIL drop_s_enable_held: got %b expected 1", s_enable); end
    s_ready = 1'b1;
    #1;
    tests_run++; if (req_ready !== 2'b01) begin tests_failed++; $display("FAIL drop_req_ready: got %b expected 01", req_ready); end
    $display("[TB] dropped-enable access req0 ready=%b", req_ready);
    step();
    s_ready = 1'b0;
    #1;
    tests_run++; if (s_enable !== 1'b0) begin tests_failed++; $display("FAIL drop_idle: got %b expected 0", s_enable); end
  endtask

  task automatic test_reset_mid();
    set_req(0, 1'b1, 1'b1, CTRL, 32'h0000_0077, 4'hF);
    set_req(1, 1'b1, 1'b1, CTRL, 32'h0000_0088, 4'hF);
    step();
    #1;
    tests_run++; if (grant_id !== 3'd1) begin tests_failed++; $display("FAIL mid_pre_grant: got %0d expected 1", grant_id); end
    rst_n = 1'b0;
    #1;
    tests_run++; if (s_enable !== 1'b0) begin tests_failed++; $display("FAIL mid_async_clear: got %b expected 0", s_enable); end
    s_ready = 1'b1;
    #1;
    tests_run++; if (req_ready !== 2'b00) begin tests_failed++; $display("FAIL mid_no_ready: got %b expected 00", req_ready); end
    s_ready = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    #1;
    tests_run++; if (grant_id !== 3'd0) begin tests_failed++; $display("FAIL mid_restart_grant: got %0d expected 0", grant_id); end
    tests_run++; if (s_enable !== 1'b1) begin tests_failed++; $display("FAIL mid_restart_enable: got %b expected 1", s_enable); end
    s_ready = 1'b1;
    #1;
    tests_run++; if (req_ready !== 2'b01) begin tests_failed++; $display("FAIL mid_restart_ready: got %b expected 01", req_ready); end
    $display("[TB] post-reset access granted req%0d ready=%b", grant_id, req_ready);
    step();
    s_ready = 1'b0;
    set_req(0, 1'b0, 1'b0, '0, '0, '0);
    set_req(1, 1'b0, 1'b0, '0, '0, '0);
    #1;
  endtask

`ifdef UART_ARB_TIMEOUT_EN
  task automatic test_timeout();
    set_req(0, 1'b1, 1'b0, STATUS, '0, 4'hF);
    s_o_data = 32'h0000_00AA;
    step();
    set_req(0, 1'b0, 1'b0, '0, '0, '0);
    for (int c = 1; c <= 16; c++) begin
      #1;
      if (c < 16) begin
        tests_run++; if (req_ready !== 2'b00) begin tests_failed++; $display("FAIL tmo_early[%0d]: got %b expected 00", c, req_ready); end
      end else begin
        tests_run++; if (req_ready !== 2'b01) begin tests_failed++; $display("FAIL tmo_ready: got %b expected 01", req_ready); end
        tests_run++; if (req_bus_err !== 2'b01) begin tests_failed++; $display("FAIL tmo_bus_err: got %b expected 01", req_bus_err); end
        tests_run++; if (req_o_data !== 32'h0) begin tests_failed++; $display("FAIL tmo_o_data: got %h expected 00000000", req_o_data); end
        $display("[TB] timeout access req0 ready=%b bus_err=%b", req_ready, req_bus_err);
      end
      step();
    end
    #1;
    tests_run++; if (s_enable !== 1'b0) begin tests_failed++; $display("FAIL tmo_idle: got %b expected 0", s_enable); end
    s_o_data = '0;
  endtask
`endif

  initial begin
    test_reset();
    test_write();
    test_round_robin();
    test_read();
    test_bus_err();
    test_drop_while_granted();
    test_reset_mid();
`ifdef UART_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
